// File: rtl/karatsuba_mac_acc_pkg.sv
// Shared definitions for the product accumulate stage: FSM encodings and default widths.
package karatsuba_mac_acc_pkg;

    localparam int PW_DEF = 32;
    localparam int AW_DEF = 40;
    localparam int CW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/karatsuba_mac_acc_if.sv
// Upstream product stream and downstream result handshake of the accumulate stage.
interface karatsuba_mac_acc_if #(
    parameter int PW = 32,
    parameter int AW = 40,
    parameter int CW = 8
) ();

    logic [PW-1:0] prod_in;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] acc_out;
    logic [CW-1:0] cnt_out;
    logic          ovf_out;
    logic          out_valid;
    logic          out_ready;

    modport slave (
        input  prod_in, in_valid, in_last, out_ready,
        output in_ready, acc_out, cnt_out, ovf_out, out_valid
    );

    modport master (
        output prod_in, in_valid, in_last, out_ready,
        input  in_ready, acc_out, cnt_out, ovf_out, out_valid
    );

endinterface

// File: rtl/karatsuba_mac_acc_rca.sv
// N-bit ripple-carry adder built from a chain of full adders.
module karatsuba_mac_acc_rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[N];

endmodule

// File: rtl/karatsuba_mac_acc.sv
// Streaming dot-product stage: sums a burst of unsigned products and presents the total,
// term count and sticky carry-out flag until the downstream handshake.
module karatsuba_mac_acc
    import karatsuba_mac_acc_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    karatsuba_mac_acc_if.slave   bus
);

    state_t        state_reg;
    state_t        state_next;

    logic [AW-1:0] acc_reg;
    logic [CW-1:0] cnt_reg;
    logic          ovf_reg;

    logic [AW-1:0] prod_ext;
    logic [AW-1:0] acc_sum;
    logic          acc_cout;
    logic [CW-1:0] cnt_inc;
    logic          cnt_cout;

    logic          in_ready;
    logic          out_valid;
    logic          accept;
    logic          release_result;

    assign prod_ext       = AW'(bus.prod_in);
    assign accept         = bus.in_valid & in_ready;
    assign release_result = out_valid & bus.out_ready;

    karatsuba_mac_acc_rca #(.N(AW)) u_acc_add (
        .a    (acc_reg),
        .b    (prod_ext),
        .cin  (1'b0),
        .sum  (acc_sum),
        .cout (acc_cout)
    );

    // Incrementing an all-ones count carries out, which doubles as the saturation detect.
    karatsuba_mac_acc_rca #(.N(CW)) u_cnt_inc (
        .a    (cnt_reg),
        .b    (CW'(1)),
        .cin  (1'b0),
        .sum  (cnt_inc),
        .cout (cnt_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_next = bus.in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        if (state_reg == HOLD) begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (accept) begin
            acc_reg <= acc_sum;
            cnt_reg <= cnt_cout ? cnt_reg : cnt_inc;
            ovf_reg <= ovf_reg | acc_cout;
        end else if (release_result) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.acc_out   = acc_reg;
    assign bus.cnt_out   = cnt_reg;
    assign bus.ovf_out   = ovf_reg;

endmodule

// File: tb/tb_karatsuba_mac_acc.sv
// Directed bench for the product accumulate stage with hand-computed expectations.
module tb_karatsuba_mac_acc;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    karatsuba_mac_acc_if #(.PW(32), .AW(40), .CW(8)) bus ();

    karatsuba_mac_acc #(.PW(32), .AW(40), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p, input logic last);
        bus.prod_in  = p;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        $display("beat prod=%08h last=%0b -> acc=%010h cnt=%0d ovf=%0b out_valid=%0b",
                 p, last, bus.acc_out, bus.cnt_out, bus.ovf_out, bus.out_valid);
    endtask

    task automatic check_result(input string tag, input logic [39:0] acc, input logic [7:0] cnt,
                                input logic ovf);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_acc"}, 64'(bus.acc_out), 64'(acc));
        check({tag, "_cnt"}, 64'(bus.cnt_out), 64'(cnt));
        check({tag, "_ovf"}, 64'(bus.ovf_out), 64'(ovf));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_acc"}, 64'(bus.acc_out), 64'd0);
        check({tag, "_cnt"}, 64'(bus.cnt_out), 64'd0);
        check({tag, "_ovf"}, 64'(bus.ovf_out), 64'd0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.prod_in   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        step();
        check_idle("reset");

        // Burst 15, 35, 77
        bus.out_ready = 1'b1;
        send(32'd15, 1'b0);
        check("b1_not_valid_mid", 64'(bus.out_valid), 64'd0);
        send(32'd35, 1'b0);
        send(32'd77, 1'b1);
        check_result("b1", 40'd127, 8'd3, 1'b0);
        step();
        check_idle("b1_release");

        // Single-term burst of 65535*65535
        send(32'hFFFE0001, 1'b1);
        check_result("single", 40'h00FFFE0001, 8'd1, 1'b0);
        step();
        check_idle("single_release");

        // 300 beats: one wrap of 2^40, count saturates
        for (int i = 0; i < 300; i++) begin
            send(32'hFFFE0001, (i == 299));
            if (i == 255) check("sat_cnt_at_256", 64'(bus.cnt_out), 64'd255);
            if (i == 256) check("ovf_after_257", 64'(bus.ovf_out), 64'd1);
        end
        check_result("long", 40'h2BFDA8012C, 8'd255, 1'b1);
        step();
        check_idle("long_release");

        // Backpressure with upstream holding a beat
        bus.out_ready = 1'b0;
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        bus.prod_in  = 32'd99;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_result("bp_hold", 40'd6, 8'd3, 1'b0);
            step();
        end
        check_result("bp_end", 40'd6, 8'd3, 1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check_idle("bp_release");

        // Bubbles inside a burst
        bus.out_ready = 1'b0;
        send(32'd10, 1'b0);
        bus.in_last = 1'b1;
        step();
        bus.in_last = 1'b0;
        step();
        check("bubble_cnt", 64'(bus.cnt_out), 64'd1);
        check("bubble_state", 64'(bus.out_valid), 64'd0);
        send(32'd20, 1'b1);
        check_result("bubble", 40'd30, 8'd2, 1'b0);
        bus.out_ready = 1'b1;
        step();
        check_idle("bubble_release");

        // Async reset mid-burst discards partial sum
        bus.out_ready = 1'b0;
        send(32'd100, 1'b0);
        send(32'd200, 1'b0);
        check("pre_rst_acc", 64'(bus.acc_out), 64'd300);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_acc", 64'(bus.acc_out), 64'd0);
        check("rst_mid_cnt", 64'(bus.cnt_out), 64'd0);
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        #1 rst = 1'b0;
        step();
        check_idle("after_rst");
        send(32'd7, 1'b1);
        check_result("post_rst", 40'd7, 8'd1, 1'b0);

        // Async reset while holding a result drops out_valid without a clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_hold_valid", 64'(bus.out_valid), 64'd0);
        check("rst_hold_acc", 64'(bus.acc_out), 64'd0);
        #1 rst = 1'b0;
        step();
        check_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
